// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
//   Memory target for the LC-3b memory port. Accepts a read or write request,
//   latches it, and answers with a one-cycle mem_resp exactly LATENCY cycles
//   after the request was first seen. Word-organized RAM with byte enables.
//   Contents are not cleared by reset.
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   mem_address       byte address; word index = mem_address[WORD_ADDR_BITS:1]
//   mem_read/write    request strobes, held by the initiator until mem_resp
//   mem_byte_enable   write lane mask ([1]=15:8, [0]=7:0)
//   mem_wdata         write data
//   mem_rdata         read data, valid in the mem_resp cycle, otherwise holds
//   mem_resp          one-cycle completion pulse
//   protocol_err      sticky flag for initiator handshake violations
module lc3b_mem_responder #(
   parameter int WORD_ADDR_BITS = 9,
   parameter int LATENCY        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_resp,
   output logic        protocol_err
);

   localparam int         DEPTH    = 2**WORD_ADDR_BITS;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [15:0] ram [DEPTH];

   // Request snapshot taken at acceptance; raw strobes are kept so that
   // any later wiggle of either one is detectable.
   logic [15:0] lat_addr, lat_wdata;
   logic [1:0]  lat_be;
   logic        lat_read, lat_write;

   logic                      req, accept, busy, changed, reading, load_rdata;
   logic [WORD_ADDR_BITS-1:0] rd_idx, lat_idx;

   assign req     = mem_read | mem_write;
   assign accept  = (state == S_IDLE) && req;
   assign busy    = (state != S_IDLE);
   assign lat_idx = lat_addr[WORD_ADDR_BITS:1];

   assign changed = busy && ((mem_read        != lat_read)  ||
                             (mem_write       != lat_write) ||
                             (mem_address     != lat_addr)  ||
                             (mem_byte_enable != lat_be)    ||
                             (mem_wdata       != lat_wdata));

   // With LATENCY==1 the RAM is read on the accepting edge, before the
   // snapshot exists, so the live inputs select the word in IDLE.
   assign rd_idx  = (state == S_IDLE) ? mem_address[WORD_ADDR_BITS:1] : lat_idx;
   assign reading = (state == S_IDLE) ? (mem_read & ~mem_write) : ~lat_write;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mem_resp   = 1'b0;
      load_rdata = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               cnt_nxt   = CNT_INIT;
               state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = S_RESP;
         end
         S_RESP: begin
            mem_resp  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // rdata is loaded on the edge entering RESP so it is valid in that cycle
      if (state_nxt == S_RESP && state != S_RESP && reading) load_rdata = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         mem_rdata    <= 16'h0000;
         protocol_err <= 1'b0;
         lat_addr     <= 16'h0000;
         lat_wdata    <= 16'h0000;
         lat_be       <= 2'b00;
         lat_read     <= 1'b0;
         lat_write    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_addr  <= mem_address;
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
            lat_read  <= mem_read;
            lat_write <= mem_write;   // write wins when both strobes are high
         end
         if (load_rdata) mem_rdata <= ram[rd_idx];
         if ((accept && mem_read && mem_write) || changed) protocol_err <= 1'b1;
      end
   end

   // Write commits on the edge that ends RESP; a reset on that edge aborts it.
   always_ff @(posedge clk) begin
      if (!reset && state == S_RESP && lat_write) begin
         if (lat_be[1]) ram[lat_idx][15:8] <= lat_wdata[15:8];
         if (lat_be[0]) ram[lat_idx][7:0]  <= lat_wdata[7:0];
      end
   end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;

   logic        clk, rst;
   logic [15:0] addr  [2];
   logic        rdr   [2];
   logic        wrt   [2];
   logic [1:0]  be    [2];
   logic [15:0] wd    [2];
   logic [15:0] rdata [2];
   logic        resp  [2];
   logic        perr  [2];

   int checks = 0;
   int errors = 0;

   // instance 0: default LATENCY=3, instance 1: LATENCY=1
   lc3b_mem_responder #(.WORD_ADDR_BITS(9), .LATENCY(3)) dut (
      .clk(clk), .reset(rst), .mem_address(addr[0]), .mem_read(rdr[0]),
      .mem_write(wrt[0]), .mem_byte_enable(be[0]), .mem_wdata(wd[0]),
      .mem_rdata(rdata[0]), .mem_resp(resp[0]), .protocol_err(perr[0]));

   lc3b_mem_responder #(.WORD_ADDR_BITS(9), .LATENCY(1)) dut1 (
      .clk(clk), .reset(rst), .mem_address(addr[1]), .mem_read(rdr[1]),
      .mem_write(wrt[1]), .mem_byte_enable(be[1]), .mem_wdata(wd[1]),
      .mem_rdata(rdata[1]), .mem_resp(resp[1]), .protocol_err(perr[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Drive one request at a negedge, hold it until mem_resp, then drop it in
   // the following IDLE cycle. lat = cycles from request to resp, -1 on timeout.
   task automatic txn(input int s, input bit w, input logic [15:0] a, input logic [1:0] b,
                      input logic [15:0] d, output logic [15:0] rd, output int lat);
      @(negedge clk);
      addr[s] = a; rdr[s] = !w; wrt[s] = w; be[s] = b; wd[s] = d;
      lat = -1; rd = 16'h0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp[s]) begin lat = i; rd = rdata[s]; break; end
      end
      @(posedge clk); #1;
      rdr[s] = 1'b0; wrt[s] = 1'b0;
   endtask

   typedef struct {
      bit          w;
      logic [15:0] a;
      logic [1:0]  b;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [12];
   logic [15:0] mdl [512];
   int          widx [8];
   logic [15:0] rd, last_rd;
   int          lat;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] b);
      logic [15:0] m;
      m = {{8{b[1]}}, {8{b[0]}}};
      return (old & ~m) | (d & m);
   endfunction

   initial begin
      tbl[0]  = '{1'b1, 16'h0010, 2'b11, 16'hBEEF, 16'h0};
      tbl[1]  = '{1'b0, 16'h0010, 2'b11, 16'h0,    16'hBEEF};
      tbl[2]  = '{1'b1, 16'h0020, 2'b11, 16'h1234, 16'h0};
      tbl[3]  = '{1'b1, 16'h0020, 2'b10, 16'hAB00, 16'h0};
      tbl[4]  = '{1'b0, 16'h0020, 2'b00, 16'h0,    16'hAB34};
      tbl[5]  = '{1'b1, 16'h0020, 2'b01, 16'h00CD, 16'h0};
      tbl[6]  = '{1'b0, 16'h0020, 2'b11, 16'h0,    16'hABCD};
      tbl[7]  = '{1'b1, 16'h0020, 2'b00, 16'hFFFF, 16'h0};
      tbl[8]  = '{1'b0, 16'h0020, 2'b11, 16'h0,    16'hABCD};
      tbl[9]  = '{1'b1, 16'h0000, 2'b11, 16'h5555, 16'h0};
      tbl[10] = '{1'b0, 16'h0400, 2'b11, 16'h0,    16'h5555};
      tbl[11] = '{1'b0, 16'h0401, 2'b11, 16'h0,    16'h5555};
      widx = '{3, 17, 64, 100, 200, 255, 300, 511};

      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         addr[s] = 16'h0; rdr[s] = 1'b0; wrt[s] = 1'b0; be[s] = 2'b00; wd[s] = 16'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset resp",  16'(resp[0]), 16'h0);
      chk("reset rdata", rdata[0],     16'h0000);
      chk("reset err",   16'(perr[0]), 16'h0);
      rst = 1'b0;

      // directed table: latency, read data, rdata untouched by writes
      last_rd = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         txn(0, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, rd, lat);
         chk($sformatf("tbl%0d latency", i), 16'(lat), 16'd3);
         if (!tbl[i].w) begin
            chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp);
            last_rd = tbl[i].exp;
         end else begin
            chk($sformatf("tbl%0d rdata held", i), rd, last_rd);
         end
      end
      chk("tbl err clear", 16'(perr[0]), 16'h0);

      // LATENCY=1 instance: held read across two back-to-back transactions
      txn(1, 1'b1, 16'h0002, 2'b11, 16'hA1A1, rd, lat);
      chk("l1 preload lat", 16'(lat), 16'd1);
      txn(1, 1'b1, 16'h0004, 2'b11, 16'hB2B2, rd, lat);
      @(negedge clk);
      addr[1] = 16'h0002; rdr[1] = 1'b1;
      @(negedge clk);
      chk("l1 resp T+1",  16'(resp[1]), 16'h1);
      chk("l1 rdata 1",   rdata[1],     16'hA1A1);
      @(posedge clk); #1;
      addr[1] = 16'h0004;
      @(negedge clk);
      chk("l1 gap T+2",   16'(resp[1]), 16'h0);
      @(negedge clk);
      chk("l1 resp T+3",  16'(resp[1]), 16'h1);
      chk("l1 rdata 2",   rdata[1],     16'hB2B2);
      @(posedge clk); #1;
      rdr[1] = 1'b0;
      @(negedge clk);
      chk("l1 idle",      16'(resp[1]), 16'h0);
      chk("l1 err",       16'(perr[1]), 16'h0);

      // randomized traffic against an array model, with aliased addresses
      for (int j = 0; j < 8; j++) begin
         mdl[widx[j]] = 16'($urandom);
         txn(0, 1'b1, 16'(widx[j] << 1), 2'b11, mdl[widx[j]], rd, lat);
      end
      for (int k = 0; k < 60; k++) begin
         int          j;
         bit          w;
         logic [15:0] a, d;
         logic [1:0]  b;
         j = $urandom_range(0, 7);
         w = 1'($urandom);
         b = 2'($urandom);
         d = 16'($urandom);
         a = (16'($urandom) & 16'hFC00) | 16'(widx[j] << 1) | 16'($urandom_range(0, 1));
         txn(0, w, a, b, d, rd, lat);
         chk($sformatf("rnd%0d latency", k), 16'(lat), 16'd3);
         if (w) mdl[widx[j]] = merge(mdl[widx[j]], d, b);
         else   chk($sformatf("rnd%0d rdata a=%h", k, a), rd, mdl[widx[j]]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk("rnd err clear", 16'(perr[0]), 16'h0);

      // address changed mid-WAIT: latched address still used
      txn(0, 1'b1, 16'h0042, 2'b11, 16'h2222, rd, lat);
      @(negedge clk);
      addr[0] = 16'h0040; wrt[0] = 1'b1; rdr[0] = 1'b0; be[0] = 2'b11; wd[0] = 16'h9999;
      @(negedge clk);
      addr[0] = 16'h0042;
      lat = -1;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (resp[0]) begin lat = i; break; end
      end
      @(posedge clk); #1;
      wrt[0] = 1'b0;
      chk("chg latency", 16'(lat), 16'd3);
      chk("chg err set", 16'(perr[0]), 16'h1);
      txn(0, 1'b0, 16'h0040, 2'b11, 16'h0, rd, lat);
      chk("chg latched addr", rd, 16'h9999);
      txn(0, 1'b0, 16'h0042, 2'b11, 16'h0, rd, lat);
      chk("chg other addr", rd, 16'h2222);

      // read and write together: write taken
      @(negedge clk);
      addr[0] = 16'h0044; rdr[0] = 1'b1; wrt[0] = 1'b1; be[0] = 2'b11; wd[0] = 16'h3333;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp[0]) begin lat = i; break; end
      end
      @(posedge clk); #1;
      rdr[0] = 1'b0; wrt[0] = 1'b0;
      chk("rw latency", 16'(lat), 16'd3);
      txn(0, 1'b0, 16'h0044, 2'b11, 16'h0, rd, lat);
      chk("rw write taken", rd, 16'h3333);
      chk("err sticky", 16'(perr[0]), 16'h1);

      // reset during WAIT aborts the write
      txn(0, 1'b1, 16'h0030, 2'b11, 16'h7777, rd, lat);
      @(negedge clk);
      addr[0] = 16'h0030; wrt[0] = 1'b1; be[0] = 2'b11; wd[0] = 16'hFFFF;
      @(negedge clk);
      rst = 1'b1; wrt[0] = 1'b0;
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp[0]) lat++;
      end
      chk("rst no resp",  16'(lat),     16'd0);
      chk("rst rdata",    rdata[0],     16'h0000);
      chk("rst err",      16'(perr[0]), 16'h0);
      rst = 1'b0;
      txn(0, 1'b0, 16'h0030, 2'b11, 16'h0, rd, lat);
      chk("rst aborted write", rd, 16'h7777);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
